// File: rtl/dm_store_buffer.sv
// Posted-write store buffer between the core data-memory port and a single-port data memory.
// Stores retire into a circular FIFO. The FIFO drains to memory on cycles without a core read.
// Loads are forwarded from the youngest matching buffered store.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   dm_addr/dm_rd/dm_wr/dm_w_data core access request
//   dm_r_data                    combinational read data to the core
//   mem_addr/mem_rd/mem_wr/mem_w_data/mem_r_data/mem_wr_ready  memory side
//   stall_o                      core write not accepted this cycle
//   full_o/empty_o/count_o       occupancy decodes of registered state
module dm_store_buffer #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CNT_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic                  dm_rd,
    input  logic                  dm_wr,
    input  logic [DATA_WIDTH-1:0] dm_w_data,
    output logic [DATA_WIDTH-1:0] dm_r_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DATA_WIDTH-1:0] mem_w_data,
    input  logic [DATA_WIDTH-1:0] mem_r_data,
    input  logic                  mem_wr_ready,
    output logic                  stall_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [CNT_WIDTH-1:0]  count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]      head_q;
    logic [PTR_W-1:0]      tail_q;
    logic [CNT_WIDTH-1:0]  count_q;

    logic                  full;
    logic                  drain;
    logic                  wr_req;
    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic                  coal_hit;
    logic [PTR_W-1:0]      coal_idx;
    logic                  enq;

    assign full   = (count_q == CNT_WIDTH'(DEPTH));
    assign drain  = !rst && (count_q != '0) && !dm_rd && mem_wr_ready;
    assign wr_req = !rst && dm_wr && !dm_rd;

    // Age-ordered scan, oldest to youngest: the last match is the youngest.
    // The coalesce search skips the head when it leaves the buffer this cycle.
    always_comb begin
        logic [PTR_W-1:0] idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        coal_hit = 1'b0;
        coal_idx = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            idx = PTR_W'(head_q + PTR_W'(k));
            if (CNT_WIDTH'(k) < count_q && addr_q[idx] == dm_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[idx];
                if (!(k == 0 && drain)) begin
                    coal_hit = 1'b1;
                    coal_idx = idx;
                end
            end
        end
    end

    assign enq = wr_req && !coal_hit && (!full || drain);

    // Memory-side muxing: reads take the port, otherwise the head drains.
    always_comb begin
        mem_rd     = !rst && dm_rd;
        mem_wr     = drain;
        mem_addr   = drain ? addr_q[head_q] : dm_addr;
        mem_w_data = data_q[head_q];
        dm_r_data  = (!rst && fwd_hit) ? fwd_data : mem_r_data;
        stall_o    = wr_req && full && !coal_hit && !drain;
    end

    assign full_o  = full;
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // Pointer and occupancy state.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (enq) begin
                tail_q <= PTR_W'(tail_q + PTR_W'(1));
            end
            if (drain) begin
                head_q <= PTR_W'(head_q + PTR_W'(1));
            end
            if (enq && !drain) begin
                count_q <= CNT_WIDTH'(count_q + CNT_WIDTH'(1));
            end else if (!enq && drain) begin
                count_q <= CNT_WIDTH'(count_q - CNT_WIDTH'(1));
            end
        end
    end

    // Entry payload storage; validity comes from head/count, so no reset needed.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail_q] <= dm_addr;
            data_q[tail_q] <= dm_w_data;
        end else if (coal_hit && wr_req) begin
            data_q[coal_idx] <= dm_w_data;
        end
    end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Directed testbench for dm_store_buffer. Inputs change on the falling edge;
// outputs are checked 1 time unit later, well before the next rising edge.
module tb_dm_store_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  dm_addr;
    logic        dm_rd;
    logic        dm_wr;
    logic [15:0] dm_w_data;
    logic [15:0] dm_r_data;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_w_data;
    logic [15:0] mem_r_data;
    logic        mem_wr_ready;
    logic        stall_o;
    logic        full_o;
    logic        empty_o;
    logic [2:0]  count_o;

    int n_checks = 0;
    int n_fail   = 0;

    dm_store_buffer #(
        .ADDR_WIDTH(8), .DATA_WIDTH(16), .DEPTH(4), .CNT_WIDTH(3)
    ) dut (
        .clk(clk), .rst(rst),
        .dm_addr(dm_addr), .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_w_data(dm_w_data),
        .dm_r_data(dm_r_data),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_w_data(mem_w_data),
        .mem_r_data(mem_r_data), .mem_wr_ready(mem_wr_ready),
        .stall_o(stall_o), .full_o(full_o), .empty_o(empty_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance through one rising edge to the next falling edge.
    task automatic next();
        @(negedge clk);
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [7:0] a, input logic [15:0] d);
        dm_rd     = rd;
        dm_wr     = wr;
        dm_addr   = a;
        dm_w_data = d;
    endtask

    task automatic expect_drain(input string tag, input logic [7:0] a, input logic [15:0] d);
        chk({tag, "_mem_wr"}, 32'(mem_wr), 32'd1);
        chk({tag, "_addr"}, 32'(mem_addr), 32'(a));
        chk({tag, "_data"}, 32'(mem_w_data), 32'(d));
    endtask

    initial begin
        rst = 1'b1;
        mem_wr_ready = 1'b1;
        mem_r_data = 16'hBEEF;
        drive(1'b1, 1'b0, 8'h10, 16'h0);

        // Reset: memory strobes suppressed, read data passes through.
        next();
        #1;
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_rdata", 32'(dm_r_data), 32'hBEEF);
        next();
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 16'h0);
        mem_r_data = 16'h0000;
        #1;
        chk("rst_empty", 32'(empty_o), 32'd1);
        chk("rst_full", 32'(full_o), 32'd0);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        for (int i = 0; i < 5; i++) begin
            next();
            #1;
            chk("idle_mem_wr", 32'(mem_wr), 32'd0);
            chk("idle_empty", 32'(empty_o), 32'd1);
        end

        // Store then load of the same address: forwarded, drain held off by the read.
        next();
        drive(1'b0, 1'b1, 8'h10, 16'h1234);
        #1;
        chk("fwd_wr_stall", 32'(stall_o), 32'd0);
        chk("fwd_wr_nodrain", 32'(mem_wr), 32'd0);
        next();
        drive(1'b1, 1'b0, 8'h10, 16'h0);
        #1;
        chk("fwd_rdata", 32'(dm_r_data), 32'h1234);
        chk("fwd_mem_rd", 32'(mem_rd), 32'd1);
        chk("fwd_mem_wr", 32'(mem_wr), 32'd0);
        chk("fwd_count", 32'(count_o), 32'd1);
        next();
        drive(1'b0, 1'b0, 8'h00, 16'h0);
        #1;
        expect_drain("fwd_drain", 8'h10, 16'h1234);
        next();
        #1;
        chk("fwd_count0", 32'(count_o), 32'd0);
        chk("fwd_idle", 32'(mem_wr), 32'd0);

        // Coalescing two stores to one address.
        mem_wr_ready = 1'b0;
        drive(1'b0, 1'b1, 8'h20, 16'h0001);
        next();
        drive(1'b0, 1'b1, 8'h20, 16'h0002);
        #1;
        chk("coal_stall", 32'(stall_o), 32'd0);
        next();
        drive(1'b0, 1'b0, 8'h00, 16'h0);
        #1;
        chk("coal_count", 32'(count_o), 32'd1);
        chk("coal_nodrain", 32'(mem_wr), 32'd0);
        mem_wr_ready = 1'b1;
        #1;
        expect_drain("coal_drain", 8'h20, 16'h0002);
        next();
        #1;
        chk("coal_count0", 32'(count_o), 32'd0);
        chk("coal_one_drain", 32'(mem_wr), 32'd0);

        // Fill under back-pressure, stall, then simultaneous enqueue and drain.
        mem_wr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 8'(8'h30 + i), 16'(16'hA0 + i));
            next();
        end
        drive(1'b0, 1'b1, 8'h34, 16'h00A4);
        #1;
        chk("full_full", 32'(full_o), 32'd1);
        chk("full_count", 32'(count_o), 32'd4);
        chk("full_stall", 32'(stall_o), 32'd1);
        next();
        #1;
        chk("full_hold_count", 32'(count_o), 32'd4);
        chk("full_hold_stall", 32'(stall_o), 32'd1);
        // Illegal rd+wr: read served, write dropped, no stall.
        drive(1'b1, 1'b1, 8'h31, 16'hFFFF);
        #1;
        chk("rdwr_stall", 32'(stall_o), 32'd0);
        chk("rdwr_rdata", 32'(dm_r_data), 32'h00A1);
        next();
        drive(1'b0, 1'b1, 8'h34, 16'h00A4);
        #1;
        chk("rdwr_count", 32'(count_o), 32'd4);
        mem_wr_ready = 1'b1;
        #1;
        chk("full_ready_stall", 32'(stall_o), 32'd0);
        expect_drain("full_drain0", 8'h30, 16'h00A0);
        next();
        drive(1'b0, 1'b0, 8'h00, 16'h0);
        #1;
        chk("full_swap_count", 32'(count_o), 32'd4);
        chk("full_swap_full", 32'(full_o), 32'd1);
        for (int i = 0; i < 4; i++) begin
            #1;
            expect_drain("full_order", 8'(8'h31 + i), 16'(16'hA1 + i));
            next();
        end
        #1;
        chk("full_empty", 32'(empty_o), 32'd1);

        // Read priority: three read cycles block draining.
        mem_wr_ready = 1'b0;
        drive(1'b0, 1'b1, 8'h40, 16'h00B0);
        next();
        drive(1'b0, 1'b1, 8'h41, 16'h00B1);
        next();
        drive(1'b1, 1'b0, 8'h50, 16'h0);
        mem_r_data = 16'h5555;
        mem_wr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rdpri_mem_wr", 32'(mem_wr), 32'd0);
            chk("rdpri_rdata", 32'(dm_r_data), 32'h5555);
            chk("rdpri_count", 32'(count_o), 32'd2);
            next();
        end
        drive(1'b0, 1'b0, 8'h00, 16'h0);
        #1;
        expect_drain("rdpri_d0", 8'h40, 16'h00B0);
        next();
        #1;
        expect_drain("rdpri_d1", 8'h41, 16'h00B1);
        next();
        #1;
        chk("rdpri_count0", 32'(count_o), 32'd0);

        // Reset with three entries buffered discards them.
        mem_wr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 8'(8'h60 + i), 16'(16'hC0 + i));
            next();
        end
        drive(1'b1, 1'b0, 8'h61, 16'h0);
        #1;
        chk("mid_count3", 32'(count_o), 32'd3);
        chk("mid_fwd", 32'(dm_r_data), 32'h00C1);
        drive(1'b0, 1'b0, 8'h00, 16'h0);
        rst = 1'b1;
        mem_wr_ready = 1'b1;
        #1;
        chk("mid_rst_mem_wr", 32'(mem_wr), 32'd0);
        next();
        rst = 1'b0;
        #1;
        chk("mid_count0", 32'(count_o), 32'd0);
        chk("mid_empty", 32'(empty_o), 32'd1);
        drive(1'b1, 1'b0, 8'h61, 16'h0);
        mem_r_data = 16'h7777;
        #1;
        chk("mid_rdata", 32'(dm_r_data), 32'h7777);
        next();
        drive(1'b0, 1'b0, 8'h00, 16'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mid_no_drain", 32'(mem_wr), 32'd0);
            next();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
